// File: rtl/pwm_capture.sv
// Pulse-train capture: synchronizes pwm_in, detects rising edges and measures
// period and high time in clk_in cycles, publishing each result with a valid strobe.
module pwm_capture #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s_in;
  logic                   w_rise;
  logic [CNT_W-1:0]       r_per_ctr;
  logic [CNT_W-1:0]       r_hi_ctr;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   w_start;
  logic                   w_publish;
  logic                   w_count;
  logic                   w_clear;
  logic                   w_ovf_set;

  assign w_s_in = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s_in & ~r_s_d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_publish   = 1'b0;
    w_count     = 1'b0;
    w_clear     = 1'b0;
    w_ovf_set   = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_clear     = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_MEAS;
            w_start     = 1'b1;
          end
        end
        ST_MEAS: begin
          // A rise both closes the current window and opens the next one.
          if (w_rise) begin
            w_publish = 1'b1;
            w_start   = 1'b1;
          end else if (r_per_ctr == CNT_MAX) begin
            w_ovf_set   = 1'b1;
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_count = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_per_ctr  <= '0;
      r_hi_ctr   <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= w_publish;
      if (w_publish) begin
        r_period <= r_per_ctr;
        r_high   <= r_hi_ctr;
      end
      if (w_start) begin
        r_per_ctr <= CNT_ONE;
        r_hi_ctr  <= CNT_ONE;
      end else if (w_clear) begin
        r_per_ctr <= '0;
        r_hi_ctr  <= '0;
      end else if (w_count) begin
        r_per_ctr <= r_per_ctr + CNT_ONE;
        if (w_s_in) r_hi_ctr <= r_hi_ctr + CNT_ONE;
      end
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign period_cnt = r_period;
  assign high_cnt   = r_high;
  assign valid      = r_valid;
  assign overflow   = r_overflow;
  assign busy       = (r_state == ST_MEAS);

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the period and high time of an external pulse train (PWM or divided clock) in units of `clk_in` cycles. It is the capture/decode counterpart of the PWM generation path in the `wb_pwm` peripheral. It synchronizes the asynchronous input, detects rising edges, counts, and publishes each completed measurement with a one-cycle valid strobe for the bus-side register block.

## Interface
Parameters:
- `CNT_W`, 32: width of internal counters and result outputs.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer; minimum 2.

Ports (clock and reset first):
- `clk_in`, input, 1: system clock; all logic runs on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: capture enable; when low, the block stays in IDLE.
- `pwm_in`, input, 1: asynchronous pulse input to be measured.
- `clr_ovf`, input, 1: single-cycle clear of the sticky `overflow` flag.
- `period_cnt`, output, `CNT_W`: last measured period, in cycles.
- `high_cnt`, output, `CNT_W`: last measured high time, in cycles.
- `valid`, output, 1: one-cycle pulse when `period_cnt` and `high_cnt` update.
- `overflow`, output, 1: sticky flag; set when a period exceeds the counter range.
- `busy`, output, 1: high while a measurement window is open (state MEAS).

## Operation
- **Reset** (`reset`=0, asynchronous) clears everything: synchronizer flops, edge register, counters, `period_cnt`, `high_cnt`, `valid`, `overflow` and `busy` all go to 0. State goes to IDLE.
- **Synchronizer:** `pwm_in` passes through `SYNC_STAGES` flops to give `s_in`. A further register `s_d` holds the previous value. A rise is detected when `s_in`=1 and `s_d`=0.
- **State machine:** two states, IDLE and MEAS.
  - IDLE → MEAS on a rise while `enable`=1. On entry, `per_ctr` and `hi_ctr` are both set to 1.
  - MEAS, no rise: `per_ctr` increments every cycle. `hi_ctr` increments on every cycle where `s_in`=1.
  - MEAS, rise: `period_cnt`←`per_ctr` and `high_cnt`←`hi_ctr`; `valid`=1 for one cycle. Both counters reload to 1 and the state stays in MEAS, so back-to-back periods are measured with no gap.
  - MEAS, `per_ctr` = 2^`CNT_W`−1 with no rise: `overflow`←1, go to IDLE, results are not updated. The next rise starts a fresh measurement.
  - `enable`=0 in any state: go to IDLE next cycle. Counters clear; `period_cnt`, `high_cnt` and `overflow` hold.
- **Counters** use unsigned `CNT_W`-bit arithmetic and never wrap; the overflow rule above prevents wrap.
- **Result relationship:** `high_cnt` ≤ `period_cnt` always. A constant-high or constant-low input leads to overflow, never to a result.
- **Overflow clear:** `clr_ovf`=1 clears `overflow`. If set and clear happen in the same cycle, set wins.
- **Outputs** are registered; there is no combinational path from inputs to outputs.

## Timing
- Latency from a `pwm_in` rising edge to the `valid` pulse is `SYNC_STAGES`+1 cycles, measured from the first `clk_in` edge that samples `pwm_in` high.
- `valid` is high for exactly 1 cycle per completed period. The results stay stable until the next `valid`.
- The first rise after reset or enable only opens a window; the first `valid` arrives at the second rise.
- Minimum measurable period is 2 cycles; minimum high or low time is 1 cycle. Shorter pulses may be lost in the synchronizer, and no error is flagged.
- `busy`=1 exactly while in MEAS.
- Reset asserted mid-measurement aborts immediately. No `valid` is produced for the aborted period.

## Test plan
- **Square wave, 2000-cycle period, 1000 high:** after the second rise, `valid` pulses once with `period_cnt`=2000 and `high_cnt`=1000. The pulse repeats every 2000 cycles.
- **Duty sweep, 100-cycle period, high = 1, 50, 99:** `high_cnt` = 1, 50, 99 respectively, with `period_cnt`=100 each time. Check there are no gaps between consecutive `valid` pulses.
- **`CNT_W`=8, `pwm_in` held high after one rise:** after 255 cycles `overflow`=1, state returns to IDLE, results are unchanged and no `valid` is produced. A `clr_ovf` pulse then clears the flag. Check `clr_ovf` coinciding with a new overflow leaves `overflow`=1.
- **Drop `enable` mid-period:** `busy`→0 next cycle, no `valid`, previous results hold. Re-enabling requires two rises before the next `valid`.
- **Assert `reset` mid-period:** all outputs are 0 asynchronously. After release, the measurement restarts cleanly.
- **`pwm_in` toggling asynchronously to `clk_in` (random phase):** measured period is within ±1 of nominal, `high_cnt` ≤ `period_cnt`, and no X appears on any output.
